// File: rtl/hls_deadlock_pkg.sv
// Shared types and helpers for the HLS dataflow deadlock monitor.
//   state_e        : persistence FSM states (idle, armed/counting, blocked)
//   thresh_eff     : maps a THRESH of 0 onto 1
//   lowest_set_idx : index of the lowest set bit of a zero-padded channel vector (0 if none)
package hls_deadlock_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StArmed,
        StBlocked
    } state_e;

    // Upper bound on NUM_AXIS supported by lowest_set_idx.
    localparam int unsigned MaxAxis = 64;

    function automatic int unsigned thresh_eff(int unsigned thresh);
        return (thresh == 0) ? 1 : thresh;
    endfunction

    function automatic int unsigned lowest_set_idx(logic [MaxAxis-1:0] vec);
        int unsigned idx;
        idx = 0;
        // Descending scan so the lowest set bit is the last one written.
        for (int i = MaxAxis - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = unsigned'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/hls_deadlock_param_monitor_if.sv
// Status bundle between a dataflow region and its deadlock monitor.
//   master : region side, drives the stall/idle/block flags, observes the status
//   slave  : monitor side, samples the flags, drives info/block/pending/index/count
interface hls_deadlock_param_monitor_if #(
    parameter int unsigned NUM_AXIS = 3,
    parameter int unsigned NUM_INST = 2,
    parameter int unsigned NUM_BLK  = 1,
    parameter int unsigned CNT_W    = 8
);
    localparam int unsigned IdxW = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;

    logic [NUM_AXIS-1:0]          axis_block_sigs;
    logic [NUM_INST-1:0]          inst_idle_sigs;
    logic [NUM_BLK-1:0]           inst_block_sigs;
    logic [NUM_AXIS*NUM_AXIS-1:0] axis_block_info;
    logic                         block;
    logic                         block_pending;
    logic [IdxW-1:0]              first_axis_idx;
    logic [CNT_W-1:0]             event_count;

    modport master (
        output axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        input  axis_block_info, block, block_pending, first_axis_idx, event_count
    );

    modport slave (
        input  axis_block_sigs, inst_idle_sigs, inst_block_sigs,
        output axis_block_info, block, block_pending, first_axis_idx, event_count
    );

endinterface

// File: rtl/hls_deadlock_persist_cnt.sv
// Persistence filter: declares a block once candidate_i has held for THRESH consecutive
// edges. With STICKY=1 the blocked state is held until clear_i.
//   clk_i, rst_ni : clock, async active-low reset
//   clear_i       : sync clear to idle, count 0 (wins over candidate_i)
//   candidate_i   : deadlock candidate for this edge
//   fire_o        : this edge enters the blocked state (combinational, for capture)
//   pending_o     : armed, persistence count running
//   block_o       : blocked state
module hls_deadlock_persist_cnt
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned THRESH = 1,
    parameter bit          STICKY = 1'b0
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic candidate_i,
    output logic fire_o,
    output logic pending_o,
    output logic block_o
);

    localparam int unsigned     ThreshEff = thresh_eff(THRESH);
    localparam int unsigned     CntW      = $clog2(ThreshEff + 1);
    localparam logic [CntW-1:0] CntLast   = CntW'(ThreshEff - 1);

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fire_o  = 1'b0;
        if (clear_i) begin
            state_d = StIdle;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (candidate_i) begin
                        if (ThreshEff == 1) begin
                            state_d = StBlocked;
                            fire_o  = 1'b1;
                        end else begin
                            state_d = StArmed;
                            cnt_d   = CntW'(1);
                        end
                    end
                end
                StArmed: begin
                    if (!candidate_i) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end else if (cnt_q == CntLast) begin
                        state_d = StBlocked;
                        cnt_d   = '0;
                        fire_o  = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CntW'(1);
                    end
                end
                StBlocked: begin
                    if (!STICKY && !candidate_i) begin
                        state_d = StIdle;
                        cnt_d   = '0;
                    end
                end
                default: begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    assign pending_o = (state_q == StArmed);
    assign block_o   = (state_q == StBlocked);

endmodule

// File: rtl/hls_deadlock_param_monitor.sv
// HLS dataflow deadlock monitor. Flags a deadlock when some sub-instance is blocked, not all
// instances are idle and some stream is stalled, persisting for THRESH edges. Reports the
// per-channel block pattern, the lowest blocked channel at entry and a saturating entry count.
//   clock, reset_n : clock, async active-low reset
//   clear          : sync clear of state, info, index and counter
//   mon (slave)    : flags in; axis_block_info/block/block_pending/first_axis_idx/event_count out
module hls_deadlock_param_monitor
    import hls_deadlock_pkg::*;
#(
    parameter int unsigned NUM_AXIS = 3,
    parameter int unsigned NUM_INST = 2,
    parameter int unsigned NUM_BLK  = 1,
    parameter int unsigned THRESH   = 1,
    parameter bit          STICKY   = 1'b0,
    parameter int unsigned CNT_W    = 8
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic                        clear,
    hls_deadlock_param_monitor_if.slave mon
);

    localparam int unsigned         IdxW    = (NUM_AXIS > 1) ? $clog2(NUM_AXIS) : 1;
    localparam int unsigned         InfoW   = NUM_AXIS * NUM_AXIS;
    localparam logic [NUM_AXIS-1:0] AxisOne = NUM_AXIS'(1);

    logic [NUM_AXIS-1:0] axis_w;
    logic [NUM_INST-1:0] idle_w;
    logic [NUM_BLK-1:0]  blk_w;
    logic                candidate;
    logic                fire, pending, block;

    logic [InfoW-1:0] info_q, info_d, info_live;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic [CNT_W-1:0] evt_q, evt_d;

    assign axis_w    = mon.axis_block_sigs;
    assign idle_w    = mon.inst_idle_sigs;
    assign blk_w     = mon.inst_block_sigs;
    assign candidate = (|blk_w) & ~(&idle_w) & (|axis_w);

    hls_deadlock_persist_cnt #(
        .THRESH (THRESH),
        .STICKY (STICKY)
    ) u_persist (
        .clk_i       (clock),
        .rst_ni      (reset_n),
        .clear_i     (clear),
        .candidate_i (candidate),
        .fire_o      (fire),
        .pending_o   (pending),
        .block_o     (block)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            info_q <= '0;
            idx_q  <= '0;
            evt_q  <= '0;
        end else begin
            info_q <= info_d;
            idx_q  <= idx_d;
            evt_q  <= evt_d;
        end
    end

    always_comb begin
        // Field i carries a mask with only bit i cleared when channel i is stalled.
        info_live = '0;
        for (int i = 0; i < NUM_AXIS; i++) begin
            if (axis_w[i]) begin
                info_live[i*NUM_AXIS +: NUM_AXIS] = ~(AxisOne << i);
            end
        end

        info_d = info_live;
        idx_d  = idx_q;
        evt_d  = evt_q;
        if (clear) begin
            info_d = '0;
            idx_d  = '0;
            evt_d  = '0;
        end else begin
            // Sticky deadlock keeps the pattern seen on the entry edge.
            if (STICKY && block) begin
                info_d = info_q;
            end
            if (fire) begin
                idx_d = IdxW'(lowest_set_idx(MaxAxis'(axis_w)));
                if (evt_q != '1) begin
                    evt_d = evt_q + CNT_W'(1);
                end
            end
        end
    end

    assign mon.axis_block_info = block ? info_q : '0;
    assign mon.block           = block;
    assign mon.block_pending   = pending;
    assign mon.first_axis_idx  = idx_q;
    assign mon.event_count     = evt_q;

endmodule

// File: tb/tb_hls_deadlock_param_monitor.sv
// Three monitors share one stimulus stream:
//   dut 0: THRESH=1 STICKY=0 CNT_W=8
//   dut 1: THRESH=4 STICKY=0 CNT_W=2
//   dut 2: THRESH=3 STICKY=1 CNT_W=8
// Expected values come from a run-length model of the candidate condition.
module tb_hls_deadlock_param_monitor;

    logic       clock   = 1'b0;
    logic       reset_n = 1'b0;
    logic       clear   = 1'b0;
    logic [2:0] axis_in = '0;
    logic [1:0] idle_in = '0;
    logic       blk_in  = 1'b0;

    int vectors = 0;
    int errors  = 0;

    always #5 clock = ~clock;

    hls_deadlock_param_monitor_if #(.NUM_AXIS(3), .NUM_INST(2), .NUM_BLK(1), .CNT_W(8)) if_a ();
    hls_deadlock_param_monitor_if #(.NUM_AXIS(3), .NUM_INST(2), .NUM_BLK(1), .CNT_W(2)) if_b ();
    hls_deadlock_param_monitor_if #(.NUM_AXIS(3), .NUM_INST(2), .NUM_BLK(1), .CNT_W(8)) if_c ();

    assign if_a.axis_block_sigs = axis_in;
    assign if_a.inst_idle_sigs  = idle_in;
    assign if_a.inst_block_sigs = blk_in;
    assign if_b.axis_block_sigs = axis_in;
    assign if_b.inst_idle_sigs  = idle_in;
    assign if_b.inst_block_sigs = blk_in;
    assign if_c.axis_block_sigs = axis_in;
    assign if_c.inst_idle_sigs  = idle_in;
    assign if_c.inst_block_sigs = blk_in;

    hls_deadlock_param_monitor #(
        .NUM_AXIS(3), .NUM_INST(2), .NUM_BLK(1), .THRESH(1), .STICKY(1'b0), .CNT_W(8)
    ) dut_a (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .mon     (if_a)
    );

    hls_deadlock_param_monitor #(
        .NUM_AXIS(3), .NUM_INST(2), .NUM_BLK(1), .THRESH(4), .STICKY(1'b0), .CNT_W(2)
    ) dut_b (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .mon     (if_b)
    );

    hls_deadlock_param_monitor #(
        .NUM_AXIS(3), .NUM_INST(2), .NUM_BLK(1), .THRESH(3), .STICKY(1'b1), .CNT_W(8)
    ) dut_c (
        .clock   (clock),
        .reset_n (reset_n),
        .clear   (clear),
        .mon     (if_c)
    );

    // Observation vector: {block, pending, info[8:0], idx[1:0], count[7:0]}
    logic [20:0] obs_all [3];
    assign obs_all[0] = {if_a.block, if_a.block_pending, if_a.axis_block_info,
                         if_a.first_axis_idx, if_a.event_count};
    assign obs_all[1] = {if_b.block, if_b.block_pending, if_b.axis_block_info,
                         if_b.first_axis_idx, 6'b0, if_b.event_count};
    assign obs_all[2] = {if_c.block, if_c.block_pending, if_c.axis_block_info,
                         if_c.first_axis_idx, if_c.event_count};

    // ---------------- reference model ----------------
    int         thr    [3] = '{1, 4, 3};
    bit         sticky [3] = '{1'b0, 1'b0, 1'b1};
    int         cmax   [3] = '{255, 3, 255};
    int         run    [3];
    bit         blk_m  [3];
    bit         pend_m [3];
    logic [8:0] info_m [3];
    logic [1:0] idx_m  [3];
    int         cnt_m  [3];

    function automatic logic [8:0] build_info(logic [2:0] a);
        logic [8:0] r;
        logic [2:0] one;
        r   = '0;
        one = 3'b001;
        for (int i = 0; i < 3; i++) begin
            if (a[i]) r[i*3 +: 3] = ~(one << i);
        end
        return r;
    endfunction

    function automatic logic [1:0] lowest(logic [2:0] a);
        for (int i = 0; i < 3; i++) begin
            if (a[i]) return 2'(i);
        end
        return 2'd0;
    endfunction

    function automatic logic [20:0] exp_vec(int k);
        return {blk_m[k], pend_m[k], blk_m[k] ? info_m[k] : 9'b0, idx_m[k], 8'(cnt_m[k])};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            run[k] = 0; blk_m[k] = 0; pend_m[k] = 0;
            info_m[k] = '0; idx_m[k] = '0; cnt_m[k] = 0;
        end
    endtask

    // Applies the inputs present at this edge.
    task automatic model_edge();
        bit cand, was_blk, entered;
        cand = (blk_in == 1'b1) && (idle_in != 2'b11) && (axis_in != 3'b000);
        for (int k = 0; k < 3; k++) begin
            if (clear) begin
                run[k] = 0; blk_m[k] = 0; pend_m[k] = 0;
                info_m[k] = '0; idx_m[k] = '0; cnt_m[k] = 0;
            end else begin
                was_blk = blk_m[k];
                if (!(sticky[k] && was_blk)) info_m[k] = build_info(axis_in);
                if (!cand) run[k] = 0;
                else if (run[k] < 1000) run[k]++;
                if (sticky[k]) begin
                    entered  = !was_blk && (run[k] == thr[k]);
                    blk_m[k] = was_blk || entered;
                end else begin
                    entered  = (run[k] == thr[k]);
                    blk_m[k] = (run[k] >= thr[k]);
                end
                pend_m[k] = !blk_m[k] && (run[k] > 0);
                if (entered) begin
                    idx_m[k] = lowest(axis_in);
                    if (cnt_m[k] < cmax[k]) cnt_m[k]++;
                end
            end
        end
    endtask

    task automatic tick();
        @(posedge clock);
        model_edge();
        #1;
    endtask

    task automatic set_cand(logic [2:0] axis);
        axis_in = axis;
        blk_in  = 1'b1;
        idle_in = 2'b01;
    endtask

    task automatic set_quiet();
        axis_in = '0;
        blk_in  = 1'b0;
        idle_in = 2'b11;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n = 1'b0;
        set_quiet();
        model_reset();
        #12;
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_all[k] !== 21'b0) begin
                errors++;
                $display("FAIL reset dut%0d got %h want %h", k, obs_all[k], 21'b0);
            end
        end
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_single_cycle();
        clear = 1'b1; tick(); clear = 1'b0;
        set_cand(3'b010);
        tick();
        vectors++;
        if (obs_all[0] !== {1'b1, 1'b0, 9'b000_101_000, 2'd1, 8'd1}) begin
            errors++;
            $display("FAIL single_cycle_entry got %h want %h", obs_all[0],
                     {1'b1, 1'b0, 9'b000_101_000, 2'd1, 8'd1});
        end
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_all[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL single_cycle dut%0d got %h want %h", k, obs_all[k], exp_vec(k));
            end
        end
        set_quiet();
        tick();
        vectors++;
        if (if_a.block !== 1'b0 || if_a.event_count !== 8'd1) begin
            errors++;
            $display("FAIL single_cycle_exit block %b count %0d want 0 and 1",
                     if_a.block, if_a.event_count);
        end
    endtask

    task automatic test_persistence();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int n = 0; n < 8; n++) begin
            if (n == 3) set_quiet();
            else set_cand(3'b100);
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_all[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL persistence edge%0d dut%0d got %h want %h", n, k, obs_all[k],
                             exp_vec(k));
                end
            end
        end
        vectors++;
        if (obs_all[1] !== {1'b1, 1'b0, 9'b011_000_000, 2'd2, 8'd1}) begin
            errors++;
            $display("FAIL persistence_rise got %h want %h", obs_all[1],
                     {1'b1, 1'b0, 9'b011_000_000, 2'd2, 8'd1});
        end
        set_quiet();
        tick();
    endtask

    task automatic test_sticky();
        clear = 1'b1; tick(); clear = 1'b0;
        set_cand(3'b110);
        for (int n = 0; n < 4; n++) begin
            if (n == 3) axis_in = 3'b001;
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_all[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL sticky edge%0d dut%0d got %h want %h", n, k, obs_all[k],
                             exp_vec(k));
                end
            end
        end
        vectors++;
        if (obs_all[2] !== {1'b1, 1'b0, 9'b011_101_000, 2'd1, 8'd1}) begin
            errors++;
            $display("FAIL sticky_hold got %h want %h", obs_all[2],
                     {1'b1, 1'b0, 9'b011_101_000, 2'd1, 8'd1});
        end
        clear = 1'b1; tick(); clear = 1'b0;
        vectors++;
        if (obs_all[2] !== 21'b0) begin
            errors++;
            $display("FAIL sticky_clear got %h want %h", obs_all[2], 21'b0);
        end
        set_quiet();
        tick();
    endtask

    task automatic test_clear_collision();
        clear = 1'b1; tick(); clear = 1'b0;
        set_cand(3'b011);
        for (int n = 0; n < 9; n++) begin
            clear = (n == 2);
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_all[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL clear_collision edge%0d dut%0d got %h want %h", n, k,
                             obs_all[k], exp_vec(k));
                end
            end
        end
        clear = 1'b0;
        set_quiet();
        tick();
    endtask

    task automatic test_saturation();
        clear = 1'b1; tick(); clear = 1'b0;
        for (int ep = 0; ep < 5; ep++) begin
            set_cand(3'b001);
            repeat (4) tick();
            set_quiet();
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_all[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL saturation ep%0d dut%0d got %h want %h", ep, k, obs_all[k],
                             exp_vec(k));
                end
            end
        end
        vectors++;
        if (if_b.event_count !== 2'd3) begin
            errors++;
            $display("FAIL saturation_count got %0d want 3", if_b.event_count);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            clear   = ($urandom_range(0, 99) < 3);
            blk_in  = ($urandom_range(0, 9) < 8);
            idle_in = ($urandom_range(0, 9) < 8) ? 2'($urandom_range(0, 2)) : 2'b11;
            axis_in = ($urandom_range(0, 9) < 9) ? 3'($urandom_range(1, 7)) : 3'b000;
            tick();
            for (int k = 0; k < 3; k++) begin
                vectors++;
                if (obs_all[k] !== exp_vec(k)) begin
                    errors++;
                    $display("FAIL random cyc%0d dut%0d got %h want %h", n, k, obs_all[k],
                             exp_vec(k));
                end
            end
        end
        clear = 1'b0;
    endtask

    task automatic test_async_reset();
        clear = 1'b1; tick(); clear = 1'b0;
        set_cand(3'b101);
        repeat (5) tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_all[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL async_pre dut%0d got %h want %h", k, obs_all[k], exp_vec(k));
            end
        end
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_all[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL async_reset dut%0d got %h want %h", k, obs_all[k], exp_vec(k));
            end
        end
        #1;
        set_quiet();
        reset_n = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            vectors++;
            if (obs_all[k] !== exp_vec(k)) begin
                errors++;
                $display("FAIL async_release dut%0d got %h want %h", k, obs_all[k], exp_vec(k));
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_cycle();
        test_persistence();
        test_sticky();
        test_clear_collision();
        test_saturation();
        test_random();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
